vertical_lift_step: RTL and testbench
=====================================

VERTICAL_LIFT_STEP -- requirements
Module: vertical_lift_step

Interface
REQ-001 SHALL have parameter DataWidth, default 16: signed sample width; each beat carries one even-row and one odd-row sample.
REQ-002 SHALL have parameter MaximumSideSize, default 512: line-buffer depth and maximum columns per line pair.
REQ-003 SHALL have parameter CoefWidth, default 16: signed lifting-coefficient width.
REQ-004 SHALL have parameter CoefFrac, default 14: fractional bits of Coef.
REQ-005 SHALL have parameter Coef, default 8192 (0.5 in Q.14): the lifting coefficient.
REQ-006 SHALL have port clk_i, input, 1: the single clock.
REQ-007 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port side_size_i, input, $clog2(MaximumSideSize): columns per line, valid 1..MaximumSideSize-1, latched on the first beat of a frame.
REQ-009 SHALL have port din_valid_i/din_ready_o, in/out, 1: input handshake.
REQ-010 SHALL have port din_eol_i, input, 1: last column of a line pair.
REQ-011 SHALL have port din_last_i, input, 1: last line pair of the frame, qualified with din_eol_i.
REQ-012 SHALL have port din_i, input, 2*DataWidth: odd sample in the upper half, even sample in the lower half.
REQ-013 SHALL have port dout_valid_o/dout_ready_i, out/in, 1: output handshake.
REQ-014 SHALL have ports dout_eol_o and dout_last_o, output, 1 each: end of line and end of frame on output.
REQ-015 SHALL have port dout_o, output, 2*DataWidth: lifted pair, in the same packing as din_i.

Function
REQ-016 SHALL perform odd'[r][c] = odd[r][c] + R(Coef*(even[r][c] + even[r+1][c])); the even sample passes through unchanged.
REQ-017 SHALL compute the even sum at DataWidth+1 bits and the product at full width.
REQ-018 SHALL define R as: add 2^(CoefFrac-1), then arithmetic shift right by CoefFrac (floor).
REQ-019 SHALL hold the previous line pair {odd, even} in a MaximumSideSize-deep buffer addressed by the column counter.
REQ-020 SHALL implement states FILL, STREAM and FLUSH.
REQ-021 FILL: din_ready_o=1; beats are stored with no output. On eol: go to STREAM, or to FLUSH if din_last_i=1.
REQ-022 STREAM: each accepted beat emits the buffered pair r-1, lifted with the current even, and overwrites the buffer entry.
REQ-023 STREAM: eol with last=1 SHALL move to FLUSH.
REQ-024 FLUSH: din_ready_o=0; emits side_size columns of the final pair using even[r+1]=even[r] (symmetric extension).
REQ-025 FLUSH: asserts dout_eol_o and dout_last_o on the final column, then returns to FILL.
REQ-026 SHALL register dout_o; latency is 1 cycle from an accepted STREAM beat, or from a FLUSH cycle, to dout_valid_o.
REQ-027 In STREAM, din_ready_o SHALL equal dout_ready_i | ~dout_valid_o; an input beat is never dropped and an output beat never changes while stalled.
REQ-028 dout_eol_o SHALL mirror the eol of the consumed input beat in STREAM; dout_last_o=0 in STREAM.
REQ-029 The column counter SHALL clear on eol.
REQ-030 A single-pair frame (last on the first eol) SHALL output that pair lifted with 2*even.

Reset
REQ-031 Asserting rst_i SHALL immediately force state FILL, column counter 0, dout_valid_o=0, dout_eol_o=0, dout_last_o=0, dout_o=0.
REQ-032 While rst_i is asserted, din_ready_o SHALL be 0.
REQ-033 Line-buffer contents SHALL not be reset; reset mid-frame discards the partial frame.

Configuration
REQ-034 With macro VERTICAL_LIFT_SAT_EN defined, the odd result SHALL saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
REQ-035 Without VERTICAL_LIFT_SAT_EN, the odd result SHALL truncate to DataWidth bits (two's-complement wrap).

Verification
REQ-036 side_size=4, two pairs, row0 even=100 odd=10, row1 even=200 odd=0 -> row0 out even=100 odd=160; row1 out even=200 odd=200 (flush); last on column 3.
REQ-037 Single pair, side_size=1, even=-3, odd=0 -> odd' = -3 (floor of -3.0); eol=last=1; state returns to FILL.
REQ-038 odd=32767, evens 1000/1000 -> 32767 with VERTICAL_LIFT_SAT_EN; -31769 without.
REQ-039 Random dout_ready_i at 50%, 8x16 frame -> output stream equals reference model bit-exactly; no lost or duplicated beats.
REQ-040 rst_i pulsed mid-STREAM -> dout_valid_o=0 the same cycle; a new 2-pair frame then processes correctly.

Source files
------------

// File: rtl/vertical_lift_step_if.sv
// Stream bundle for the vertical lifting step: even/odd sample pairs in, lifted pairs out.
// The slave modport is the lifting block's view; the master modport is the producer/consumer side.
interface vertical_lift_step_if #(
   parameter int DataWidth = 16
);
   logic                   din_valid_i;
   logic                   din_ready_o;
   logic                   din_eol_i;
   logic                   din_last_i;
   logic [2*DataWidth-1:0] din_i;

   logic                   dout_valid_o;
   logic                   dout_ready_i;
   logic                   dout_eol_o;
   logic                   dout_last_o;
   logic [2*DataWidth-1:0] dout_o;

   modport slave (
      input  din_valid_i, din_eol_i, din_last_i, din_i, dout_ready_i,
      output din_ready_o, dout_valid_o, dout_eol_o, dout_last_o, dout_o
   );

   modport master (
      output din_valid_i, din_eol_i, din_last_i, din_i, dout_ready_i,
      input  din_ready_o, dout_valid_o, dout_eol_o, dout_last_o, dout_o
   );
endinterface

// File: rtl/vertical_lift_step.sv
// Vertical lifting step odd' = odd + R(Coef*(even[r]+even[r+1])); 1-cycle registered output, input stalls when the output is held.
// Define VERTICAL_LIFT_SAT_EN to saturate the odd result instead of wrapping it.
module vertical_lift_step #(
   parameter int DataWidth       = 16,
   parameter int MaximumSideSize = 512,
   parameter int CoefWidth       = 16,
   parameter int CoefFrac        = 14,
   parameter int Coef            = 8192
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [$clog2(MaximumSideSize)-1:0] side_size_i,
   vertical_lift_step_if.slave                io
);

   localparam int ColW  = $clog2(MaximumSideSize);
   localparam int SumW  = DataWidth + 1;
   localparam int ProdW = SumW + CoefWidth;
   localparam int ResW  = ProdW + 1;

   localparam logic signed [CoefWidth-1:0] CoefS = CoefWidth'(Coef);
   localparam logic signed [ProdW-1:0]     Half  = ProdW'(2 ** (CoefFrac - 1));

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [ColW-1:0]        col_q, col_d;
   logic [ColW-1:0]        side_q, side_d;
   logic                   dout_valid_q, dout_valid_d;
   logic                   dout_eol_q, dout_eol_d;
   logic                   dout_last_q, dout_last_d;
   logic [2*DataWidth-1:0] dout_q, dout_d;

   logic [2*DataWidth-1:0] line_buf_q [MaximumSideSize];
   logic                   buf_we;
   logic [2*DataWidth-1:0] buf_rd;

   logic signed [DataWidth-1:0] even_prev, odd_prev, even_nxt;
   logic signed [SumW-1:0]      even_sum;
   logic signed [ProdW-1:0]     prod, rounded;
   logic signed [ResW-1:0]      odd_full;
   logic [DataWidth-1:0]        odd_lift;

   logic out_free;
   logic din_rdy;
   logic last_col;

   // Buffer holds the previous row pair {odd, even} for the current column.
   assign buf_rd    = line_buf_q[col_q];
   assign even_prev = buf_rd[DataWidth-1:0];
   assign odd_prev  = buf_rd[2*DataWidth-1:DataWidth];
   assign out_free  = io.dout_ready_i | ~dout_valid_q;
   assign last_col  = (col_q == side_q - ColW'(1));

   always_comb begin
      // Final row has no successor, so it is mirrored onto itself.
      even_nxt = even_prev;
      if (state_q == STREAM) begin
         even_nxt = io.din_i[DataWidth-1:0];
      end
      even_sum = {even_prev[DataWidth-1], even_prev} + {even_nxt[DataWidth-1], even_nxt};
      prod     = $signed({{CoefWidth{even_sum[SumW-1]}}, even_sum})
               * $signed({{SumW{CoefS[CoefWidth-1]}}, CoefS});
      rounded  = (prod + Half) >>> CoefFrac;
      odd_full = {{(ResW-DataWidth){odd_prev[DataWidth-1]}}, odd_prev}
               + {rounded[ProdW-1], rounded};
   end

`ifdef VERTICAL_LIFT_SAT_EN
   localparam logic signed [ResW-1:0] MaxV = ResW'(2 ** (DataWidth - 1) - 1);
   localparam logic signed [ResW-1:0] MinV = -MaxV - ResW'(1);

   always_comb begin
      odd_lift = odd_full[DataWidth-1:0];
      if (odd_full > MaxV) begin
         odd_lift = MaxV[DataWidth-1:0];
      end else if (odd_full < MinV) begin
         odd_lift = MinV[DataWidth-1:0];
      end
   end
`else
   always_comb begin
      odd_lift = odd_full[DataWidth-1:0];
   end
`endif

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      side_d       = side_q;
      dout_valid_d = dout_valid_q & ~io.dout_ready_i;
      dout_eol_d   = dout_eol_q;
      dout_last_d  = dout_last_q;
      dout_d       = dout_q;
      din_rdy      = 1'b0;
      buf_we       = 1'b0;

      case (state_q)
         FILL: begin
            din_rdy = 1'b1;
            if (io.din_valid_i) begin
               buf_we = 1'b1;
               if (col_q == '0) begin
                  side_d = side_size_i;
               end
               if (io.din_eol_i) begin
                  col_d   = '0;
                  state_d = io.din_last_i ? FLUSH : STREAM;
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end

         STREAM: begin
            din_rdy = out_free;
            if (io.din_valid_i && out_free) begin
               buf_we       = 1'b1;
               dout_valid_d = 1'b1;
               dout_d       = {odd_lift, even_prev};
               dout_eol_d   = io.din_eol_i;
               dout_last_d  = 1'b0;
               if (io.din_eol_i) begin
                  col_d = '0;
                  if (io.din_last_i) begin
                     state_d = FLUSH;
                  end
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end

         FLUSH: begin
            if (out_free) begin
               dout_valid_d = 1'b1;
               dout_d       = {odd_lift, even_prev};
               dout_eol_d   = last_col;
               dout_last_d  = last_col;
               if (last_col) begin
                  col_d   = '0;
                  state_d = FILL;
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end

         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= FILL;
         col_q        <= '0;
         side_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_eol_q   <= 1'b0;
         dout_last_q  <= 1'b0;
         dout_q       <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         side_q       <= side_d;
         dout_valid_q <= dout_valid_d;
         dout_eol_q   <= dout_eol_d;
         dout_last_q  <= dout_last_d;
         dout_q       <= dout_d;
      end
   end

   // Line storage is deliberately left out of reset; a new frame refills it.
   always_ff @(posedge clk_i) begin
      if (buf_we) begin
         line_buf_q[col_q] <= io.din_i;
      end
   end

   assign io.din_ready_o  = din_rdy & ~rst_i;
   assign io.dout_valid_o = dout_valid_q;
   assign io.dout_eol_o   = dout_eol_q;
   assign io.dout_last_o  = dout_last_q;
   assign io.dout_o       = dout_q;

endmodule

// File: tb/tb_vertical_lift_step.sv
// Bench for vertical_lift_step: directed frames plus randomized frames with random output stalls,
// compared against an arithmetic row-pair reference model.
module tb_vertical_lift_step;

   localparam int DW       = 16;
   localparam int CoefFrac = 14;
   localparam int Coef     = 8192;

   typedef struct {
      logic [31:0] dat;
      logic        eol;
      logic        last;
   } beat_t;

   logic       clk_i;
   logic       rst_i;
   logic [8:0] side_size_i;
   bit         rdy_rand;

   int checks;
   int failures;

   int    ev [8][16];
   int    od [8][16];
   beat_t in_q[$];
   beat_t exp_q[$];

   vertical_lift_step_if #(.DataWidth(DW)) bus ();

   vertical_lift_step dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .side_size_i (side_size_i),
      .io          (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: odd' = odd + floor((Coef*(e0+e1) + 2^(F-1)) / 2^F), then wrap or clamp.
   function automatic logic [31:0] model_pair(input int odd, input int e0, input int e1);
      longint s, r, o;
      logic [15:0] ob, eb;
      s = longint'(e0) + longint'(e1);
      r = (s * Coef + (longint'(1) <<< (CoefFrac - 1))) >>> CoefFrac;
      o = longint'(odd) + r;
`ifdef VERTICAL_LIFT_SAT_EN
      if (o > 32767)  o = 32767;
      if (o < -32768) o = -32768;
`endif
      ob = o[15:0];
      eb = e0[15:0];
      return {ob, eb};
   endfunction

   task automatic build_frame(input int rows, input int side, input bit push_model);
      beat_t b, e;
      int    e1;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < side; c++) begin
            b.dat  = {od[r][c][15:0], ev[r][c][15:0]};
            b.eol  = (c == side - 1);
            b.last = (c == side - 1) && (r == rows - 1);
            in_q.push_back(b);
            if (push_model) begin
               e1     = (r == rows - 1) ? ev[r][c] : ev[r+1][c];
               e.dat  = model_pair(od[r][c], ev[r][c], e1);
               e.eol  = b.eol;
               e.last = b.last;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic push_exp(input logic [31:0] dat, input logic eol, input logic last);
      beat_t e;
      e.dat  = dat;
      e.eol  = eol;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic randomize_rows(input int rows, input int side);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < side; c++) begin
            ev[r][c] = int'($urandom_range(0, 65535)) - 32768;
            od[r][c] = int'($urandom_range(0, 65535)) - 32768;
         end
      end
   endtask

   task automatic send_n(input int n);
      int    cnt;
      int    guard;
      bit    acc;
      beat_t b;
      cnt   = 0;
      guard = 0;
      while (cnt < n && guard < 5000) begin
         b = in_q[0];
         bus.din_valid_i = ($urandom % 4) != 0;
         bus.din_i       = b.dat;
         bus.din_eol_i   = b.eol;
         bus.din_last_i  = b.last;
         @(negedge clk_i);
         acc = bus.din_valid_i && bus.din_ready_o;
         @(posedge clk_i);
         #1;
         if (acc) begin
            void'(in_q.pop_front());
            cnt++;
         end
         guard++;
      end
      bus.din_valid_i = 1'b0;
      check_eq("send_done", cnt, n);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 3000) begin
         @(posedge clk_i);
         g++;
      end
      repeat (3) @(posedge clk_i);
      #1;
      check_eq("drain_left", exp_q.size(), 0);
      check_eq("idle_rdy", bus.din_ready_o, 1'b1);
   endtask

   always begin
      @(posedge clk_i);
      #1;
      bus.dout_ready_i = rdy_rand ? 1'($urandom % 2) : 1'b1;
   end

   logic [31:0] prev_dat;
   bit          prev_stall;
   always @(negedge clk_i) begin
      beat_t e;
      if (rst_i) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("hold_vld", bus.dout_valid_o, 1'b1);
            check_eq("hold_dat", bus.dout_o, prev_dat);
         end
         if (bus.dout_valid_o && bus.dout_ready_i) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("dout", bus.dout_o, e.dat);
               check_eq("eol", bus.dout_eol_o, e.eol);
               check_eq("last", bus.dout_last_o, e.last);
            end
         end
         prev_stall = bus.dout_valid_o && !bus.dout_ready_i;
         prev_dat   = bus.dout_o;
      end
   end

   initial begin
      checks          = 0;
      failures        = 0;
      rdy_rand        = 1'b0;
      rst_i           = 1'b1;
      side_size_i     = 9'd4;
      bus.din_valid_i = 1'b0;
      bus.din_eol_i   = 1'b0;
      bus.din_last_i  = 1'b0;
      bus.din_i       = '0;
      bus.dout_ready_i = 1'b0;

      #3;
      check_eq("rst_dout_vld", bus.dout_valid_o, 1'b0);
      check_eq("rst_din_rdy", bus.din_ready_o, 1'b0);
      check_eq("rst_dout", bus.dout_o, 32'd0);
      check_eq("rst_eol", bus.dout_eol_o, 1'b0);
      check_eq("rst_last", bus.dout_last_o, 1'b0);
      repeat (3) @(posedge clk_i);
      #3;
      rst_i = 1'b0;

      // Two pairs, constant columns: 10 + R(0.5*300) = 160, flush 0 + R(0.5*400) = 200.
      side_size_i = 9'd4;
      for (int c = 0; c < 4; c++) begin
         ev[0][c] = 100; od[0][c] = 10;
         ev[1][c] = 200; od[1][c] = 0;
      end
      build_frame(2, 4, 1'b0);
      for (int c = 0; c < 4; c++) push_exp({16'd160, 16'd100}, c == 3, 1'b0);
      for (int c = 0; c < 4; c++) push_exp({16'd200, 16'd200}, c == 3, c == 3);
      send_n(8);
      drain();

      // Single pair: -3 + floor(-3.0 + 0.5) = -6? no: R(0.5*(-6)) = floor(-2.5) = -3, so odd' = -3.
      side_size_i = 9'd1;
      ev[0][0] = -3; od[0][0] = 0;
      build_frame(1, 1, 1'b0);
      push_exp({16'hFFFD, 16'hFFFD}, 1'b1, 1'b1);
      send_n(1);
      drain();

      // Overflow corner: 32767 + 1000.
      side_size_i = 9'd1;
      ev[0][0] = 1000; od[0][0] = 32767;
      ev[1][0] = 1000; od[1][0] = 0;
      build_frame(2, 1, 1'b0);
`ifdef VERTICAL_LIFT_SAT_EN
      push_exp({16'h7FFF, 16'd1000}, 1'b1, 1'b0);
`else
      push_exp({16'h83E7, 16'd1000}, 1'b1, 1'b0);
`endif
      push_exp({16'd1000, 16'd1000}, 1'b1, 1'b1);
      send_n(2);
      drain();

      // Random data with random output stalls.
      rdy_rand    = 1'b1;
      side_size_i = 9'd16;
      randomize_rows(8, 16);
      build_frame(8, 16, 1'b1);
      send_n(128);
      drain();

      side_size_i = 9'd5;
      randomize_rows(3, 5);
      build_frame(3, 5, 1'b1);
      send_n(15);
      drain();

      // Reset in the middle of streaming the second row.
      rdy_rand    = 1'b0;
      side_size_i = 9'd8;
      randomize_rows(2, 8);
      build_frame(2, 8, 1'b0);
      for (int c = 0; c < 3; c++) push_exp(model_pair(od[0][c], ev[0][c], ev[1][c]), 1'b0, 1'b0);
      send_n(11);
      check_eq("pre_rst_vld", bus.dout_valid_o, 1'b1);
      rst_i = 1'b1;
      #1;
      check_eq("mid_rst_vld", bus.dout_valid_o, 1'b0);
      check_eq("mid_rst_rdy", bus.din_ready_o, 1'b0);
      check_eq("mid_rst_dout", bus.dout_o, 32'd0);
      exp_q.delete();
      in_q.delete();
      repeat (2) @(posedge clk_i);
      #3;
      rst_i = 1'b0;

      rdy_rand    = 1'b1;
      side_size_i = 9'd6;
      randomize_rows(2, 6);
      build_frame(2, 6, 1'b1);
      send_n(12);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
